pulse_param_regfile: RTL and testbench

- UART-fed command decoder that owns the pulse-sequencer parameter registers.
- Generalised successor of the fixed-field pulse controller:
  - parametrised payload width and register count;
  - register readback;
  - NAK on bad frames;
  - inter-byte timeout;
  - optional shadow/commit mode, so that new parameters take effect only at a pulse-period boundary.
- Sits between the UART byte interface and the pulse generator/attenuator logic.

---
 rtl/pulse_param_regfile.sv | 230 +++++++++++++++++++++++
 tb/tb_pulse_param_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_param_regfile.sv
// pulse_param_regfile: UART-fed command decoder that owns
// the pulse-sequencer parameter registers.
module pulse_param_regfile #(
  parameter int PAYLOAD_BYTES = 4,
  parameter int NUM_REGS = 16,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int COMMIT_MODE = 0,
  parameter logic [NUM_REGS*8*PAYLOAD_BYTES-1:0]
    RESET_VALS = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_valid,
  input  logic [7:0] rx_byte,
  input  logic tx_ready,
  output logic tx_valid,
  output logic [7:0] tx_byte,
  input  logic commit_sync,
  output logic [NUM_REGS*8*PAYLOAD_BYTES-1:0] regs_flat,
  output logic update,
  output logic frame_err,
  output logic busy
);
  localparam int REG_W = 8*PAYLOAD_BYTES;
  localparam int RESP_N = PAYLOAD_BYTES+1;
  localparam logic [2:0] PB = 3'(PAYLOAD_BYTES);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC-1);

  typedef enum logic [1:0] {
    RECV, EXEC, SEND, WAIT_TX
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0] byte_cnt;
  logic [7:0] pay [PAYLOAD_BYTES];
  logic [7:0] ctrl;
  logic [31:0] idle_cnt;

  logic [REG_W-1:0] act [NUM_REGS];
  logic [REG_W-1:0] shd [NUM_REGS];
  logic pending;

  logic [7:0] resp [RESP_N];
  logic [2:0] resp_len;
  logic [2:0] resp_idx;
  logic seen_low;

  logic [REG_W-1:0] pay_word;
  logic [REG_W-1:0] rd_word;
  logic [7:0] csum;
  logic [7:0] rd_sum;
  logic in_rng;
  logic is_cmt;
  logic do_wr;
  logic do_rd;
  logic do_cc;
  logic nak;
  logic do_apply;
  logic timeout;
  logic drop;

  // Decode the captured frame and the side conditions
  always_comb begin
    pay_word = '0;
    csum = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      pay_word[i*8 +: 8] = pay[i];
      csum = csum + pay[i];
    end
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ctrl[6:0] == 7'(i)) rd_word = act[i];
    end
    rd_sum = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      rd_sum = rd_sum + rd_word[i*8 +: 8];
    end
    in_rng = 32'(ctrl[6:0]) < 32'(NUM_REGS);
    is_cmt = !ctrl[7] && (ctrl[6:0] == 7'h7f);
    do_wr = (state == EXEC) && !ctrl[7] && in_rng;
    do_rd = (state == EXEC) && ctrl[7] && in_rng;
    do_cc = (state == EXEC) && is_cmt;
    nak = (state == EXEC) && !(in_rng || is_cmt);
    do_apply = (COMMIT_MODE != 0) && commit_sync
             && (pending || do_cc);
    timeout = (state == RECV) && (byte_cnt != 3'd0)
            && !rx_valid && (idle_cnt == TO_LAST);
    drop = rx_valid && (state != RECV);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RECV;
    else state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      RECV:
        if (rx_valid && byte_cnt == PB)
          state_nx = EXEC;
      EXEC: state_nx = SEND;
      SEND:
        if (tx_ready) state_nx = WAIT_TX;
      WAIT_TX:
        if (seen_low && tx_ready)
          state_nx = (resp_idx < resp_len)
                   ? SEND : RECV;
      default: state_nx = RECV;
    endcase
  end

  // Outputs derived from state and response buffer
  always_comb begin
    tx_valid = (state == SEND) && tx_ready;
    busy = (state != RECV);
    tx_byte = '0;
    for (int i = 0; i < RESP_N; i++) begin
      if (tx_valid && resp_idx == 3'(i))
        tx_byte = resp[i];
    end
  end

  // Byte capture, inter-byte timeout and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      ctrl <= '0;
      idle_cnt <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < PAYLOAD_BYTES; i++)
        pay[i] <= '0;
    end else begin
      frame_err <= nak || timeout || drop;
      if (state == RECV && rx_valid) begin
        idle_cnt <= '0;
        if (byte_cnt == PB) begin
          ctrl <= rx_byte;
          byte_cnt <= '0;
        end else begin
          for (int i = 0; i < PAYLOAD_BYTES; i++)
            if (byte_cnt == 3'(i)) pay[i] <= rx_byte;
          byte_cnt <= byte_cnt + 3'd1;
        end
      end else if (state == RECV && byte_cnt != 3'd0) begin
        if (timeout) begin
          byte_cnt <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 32'd1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // Active/shadow registers and commit handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      update <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        act[i] <= RESET_VALS[i*REG_W +: REG_W];
        shd[i] <= RESET_VALS[i*REG_W +: REG_W];
      end
    end else begin
      update <= do_apply || (COMMIT_MODE == 0 && do_wr);
      if (do_apply) pending <= 1'b0;
      else if (COMMIT_MODE != 0 && do_cc) pending <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (do_apply)
          act[i] <= shd[i];
        else if (COMMIT_MODE == 0 && do_wr
                 && ctrl[6:0] == 7'(i))
          act[i] <= pay_word;
        if (COMMIT_MODE != 0 && do_wr
            && ctrl[6:0] == 7'(i))
          shd[i] <= pay_word;
      end
    end
  end

  // Response buffer and transmit handshake tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_len <= '0;
      resp_idx <= '0;
      seen_low <= 1'b0;
      for (int i = 0; i < RESP_N; i++)
        resp[i] <= '0;
    end else begin
      unique case (state)
        EXEC: begin
          resp_idx <= '0;
          seen_low <= 1'b0;
          if (do_rd) begin
            for (int i = 0; i < PAYLOAD_BYTES; i++)
              resp[i] <= rd_word[i*8 +: 8];
            resp[PAYLOAD_BYTES] <= rd_sum;
            resp_len <= 3'(RESP_N);
          end else begin
            resp[0] <= nak ? ~csum : csum;
            resp_len <= 3'd1;
          end
        end
        SEND:
          if (tx_ready) begin
            resp_idx <= resp_idx + 3'd1;
            seen_low <= 1'b0;
          end
        WAIT_TX:
          if (!tx_ready) seen_low <= 1'b1;
        default: ;
      endcase
    end
  end

  // Flatten the active registers
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++)
      regs_flat[i*REG_W +: REG_W] = act[i];
  end

endmodule

// File: tb/tb_pulse_param_regfile.sv
// tb_pulse_param_regfile: directed bench for the
// parameter register file, immediate and commit modes.
module tb_pulse_param_regfile;
  localparam int NR = 16;
  localparam int TO = 40;
  localparam int W = NR*32;
  localparam logic [W-1:0] RV0 = {NR{32'hA5A5_0001}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxv0 = 1'b0, rxv1 = 1'b0;
  logic [7:0] rxb0 = '0, rxb1 = '0;
  logic txr0 = 1'b1, txr1 = 1'b1;
  logic cs0 = 1'b0, cs1 = 1'b0;

  logic txv0, txv1;
  logic [7:0] txb0, txb1;
  logic [W-1:0] flat0, flat1;
  logic upd0, upd1, err0, err1, busy0, busy1;

  pulse_param_regfile #(
    .PAYLOAD_BYTES(4), .NUM_REGS(NR),
    .TIMEOUT_CYC(TO), .COMMIT_MODE(0),
    .RESET_VALS(RV0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rxv0), .rx_byte(rxb0),
    .tx_ready(txr0), .tx_valid(txv0), .tx_byte(txb0),
    .commit_sync(cs0), .regs_flat(flat0),
    .update(upd0), .frame_err(err0), .busy(busy0)
  );

  pulse_param_regfile #(
    .PAYLOAD_BYTES(4), .NUM_REGS(NR),
    .TIMEOUT_CYC(TO), .COMMIT_MODE(1),
    .RESET_VALS('0)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rxv1), .rx_byte(rxb1),
    .tx_ready(txr1), .tx_valid(txv1), .tx_byte(txb1),
    .commit_sync(cs1), .regs_flat(flat1),
    .update(upd1), .frame_err(err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int updn0 = 0, errn0 = 0, txn0 = 0;
  int updn1 = 0;
  logic [7:0] q[$];
  logic [W-1:0] exp0;
  logic [W-1:0] exp1;

  always @(posedge clk) begin
    if (upd0) updn0++;
    if (err0) errn0++;
    if (txv0) txn0++;
    if (upd1) updn1++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int k,
                            input logic [31:0] p,
                            input logic [7:0] c);
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b = (i < 4) ? p[i*8 +: 8] : c;
      if (k == 0) begin rxv0 = 1'b1; rxb0 = b; end
      else begin rxv1 = 1'b1; rxb1 = b; end
    end
    @(negedge clk);
    rxv0 = 1'b0;
    rxv1 = 1'b0;
  endtask

  task automatic collect(input int k, input int cyc);
    q.delete();
    for (int c = 0; c < cyc; c++) begin
      if ((k == 0) ? txv0 : txv1) begin
        q.push_back((k == 0) ? txb0 : txb1);
        @(negedge clk);
        if (k == 0) txr0 = 1'b0; else txr1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (k == 0) txr0 = 1'b1; else txr1 = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_q(input string tag,
                       input logic [39:0] bytes,
                       input int n);
    logic [8:0] got;
    chk({tag, "_len"}, W'(q.size()), W'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < q.size()) ? {1'b0, q[i]} : 9'h100;
      chk(tag, W'(got), W'(bytes[i*8 +: 8]));
    end
  endtask

  initial begin
    int u, e, t;
    repeat (3) @(negedge clk);
    chk("rst_txv", W'(txv0), '0);
    chk("rst_txb", W'(txb0), '0);
    chk("rst_busy", W'(busy0), '0);
    chk("rst_err", W'(err0), '0);
    chk("rst_upd", W'(upd0), '0);
    chk("rst_regs0", flat0, RV0);
    chk("rst_regs1", flat1, '0);
    rst_n = 1'b1;
    exp0 = RV0;
    exp1 = '0;

    u = updn0;
    send_frame(0, 32'h0000_2710, 8'h02);
    chk("wr_pre_regs", flat0, exp0);
    chk("wr_busy", W'(busy0), W'(1));
    chk("wr_pre_txv", W'(txv0), '0);
    @(negedge clk);
    exp0[2*32 +: 32] = 32'h0000_2710;
    chk("wr_regs", flat0, exp0);
    chk("wr_txv_t2", W'(txv0), W'(1));
    collect(0, 30);
    chk_q("wr_resp", 40'h37, 1);
    chk("wr_upd", W'(updn0 - u), W'(1));

    send_frame(0, 32'h0, 8'h82);
    collect(0, 60);
    chk_q("rd_resp", 40'h37_0000_2710, 5);

    e = errn0;
    send_frame(0, 32'h0000_00AA, 8'h20);
    collect(0, 30);
    chk_q("nak_resp", 40'h55, 1);
    chk("nak_err", W'(errn0 - e), W'(1));
    chk("nak_regs", flat0, exp0);

    e = errn0;
    send_frame(0, 32'h0403_0201, 8'h04);
    rxv0 = 1'b1;
    rxb0 = 8'hEE;
    @(negedge clk);
    rxv0 = 1'b0;
    collect(0, 30);
    exp0[4*32 +: 32] = 32'h0403_0201;
    chk_q("drop_resp", 40'h0A, 1);
    chk("drop_err", W'(errn0 - e), W'(1));
    chk("drop_regs", flat0, exp0);

    e = errn0;
    t = txn0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rxv0 = 1'b1;
      rxb0 = 8'h11;
    end
    @(negedge clk);
    rxv0 = 1'b0;
    repeat (30) @(negedge clk);
    chk("to_early", W'(errn0 - e), '0);
    repeat (30) @(negedge clk);
    chk("to_err", W'(errn0 - e), W'(1));
    chk("to_notx", W'(txn0 - t), '0);
    chk("to_regs", flat0, exp0);
    send_frame(0, 32'h0, 8'h84);
    collect(0, 60);
    chk_q("to_next", 40'h0A_0403_0201, 5);

    u = updn1;
    send_frame(1, 32'h0000_0064, 8'h05);
    collect(1, 30);
    chk_q("cm_wr_resp", 40'h64, 1);
    chk("cm_wr_regs", flat1, exp1);
    chk("cm_wr_upd", W'(updn1 - u), '0);
    send_frame(1, 32'h0, 8'h7F);
    collect(1, 30);
    chk_q("cm_cc_resp", 40'h00, 1);
    chk("cm_cc_regs", flat1, exp1);
    @(negedge clk);
    cs1 = 1'b1;
    @(negedge clk);
    cs1 = 1'b0;
    exp1[5*32 +: 32] = 32'h0000_0064;
    chk("cm_apply", flat1, exp1);
    repeat (2) @(negedge clk);
    chk("cm_upd", W'(updn1 - u), W'(1));
    cs1 = 1'b1;
    @(negedge clk);
    cs1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("cm_noupd", W'(updn1 - u), W'(1));
    chk("cm_regs2", flat1, exp1);

    send_frame(0, 32'h0, 8'h82);
    collect(0, 6);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_txv", W'(txv0), '0);
    chk("mr_busy", W'(busy0), '0);
    chk("mr_regs0", flat0, RV0);
    chk("mr_regs1", flat1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    collect(0, 30);
    chk("mr_quiet", W'(q.size()), '0);
    send_frame(0, 32'h0, 8'h83);
    collect(0, 60);
    chk_q("mr_rd", 40'h4B_A5A5_0001, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
